// File: rtl/nba_round_ctrl.sv
// Batch round sequencer: loads answers, pulses per-round reset, gathers stats.
// Optional per-round cnt log enabled with `define ROUND_LOG_EN.
module nba_round_ctrl #(
   parameter int TIMEOUT = 200,
   parameter int ADDR_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [10:0]       num_round,
   output logic [ADDR_W-1:0] ans_addr,
   input  logic [15:0]       ans_data,
   output logic [15:0]       answer,
   output logic              round_rst_n,
   input  logic [15:0]       cnt,
   input  logic              correct,
   output logic              busy,
   output logic              done,
   output logic [23:0]       total_cnt,
   output logic [10:0]       fail_cnt,
   output logic [15:0]       max_cnt
`ifdef ROUND_LOG_EN
   ,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_data
`endif
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] ARM    = 3'd2;
   localparam logic [2:0] RUN    = 3'd3;
   localparam logic [2:0] RECORD = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam int          MAXR = 2 ** ADDR_W;
   localparam logic [16:0] TO   = 17'(TIMEOUT);

   logic [2:0]        state;
   logic [2:0]        nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] last;
   logic [15:0]       cap;
   logic              cap_fail;
   logic              cnt_hit;
   logic              finish;
   logic [24:0]       sum;
   logic [23:0]       sum_sat;
   int                nr_clamp;

   assign cnt_hit  = {1'b0, cnt} >= TO;
   assign finish   = correct | cnt_hit;
   assign sum      = {1'b0, total_cnt} + {9'd0, cap};
   assign sum_sat  = sum[24] ? 24'hFFFFFF : sum[23:0];
   assign nr_clamp = (int'(num_round) > MAXR) ? MAXR : int'(num_round);

   assign ans_addr = idx;
   assign busy     = (state == LOAD) | (state == ARM) |
                     (state == RUN)  | (state == RECORD);
   assign done     = (state == DONE);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (start)
               nxt = (num_round == 11'd0) ? DONE : LOAD;
         end
         LOAD:    nxt = ARM;
         ARM:     nxt = RUN;
         RUN:     nxt = finish ? RECORD : RUN;
         RECORD:  nxt = (idx == last) ? DONE : LOAD;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         idx         <= '0;
         last        <= '0;
         answer      <= '0;
         round_rst_n <= 1'b0;
         cap         <= '0;
         cap_fail    <= 1'b0;
         total_cnt   <= '0;
         fail_cnt    <= '0;
         max_cnt     <= '0;
      end else begin
         state       <= nxt;
         // Registered from next state so the low pulse lines up with ARM.
         round_rst_n <= (nxt != ARM);
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx       <= '0;
                  last      <= ADDR_W'(nr_clamp - 1);
                  total_cnt <= '0;
                  fail_cnt  <= '0;
                  max_cnt   <= '0;
               end
            end
            LOAD: answer <= ans_data;
            RUN: begin
               if (finish) begin
                  cap      <= cnt;
                  cap_fail <= ~correct;
               end
            end
            RECORD: begin
               total_cnt <= sum_sat;
               if (cap > max_cnt)
                  max_cnt <= cap;
               if (cap_fail)
                  fail_cnt <= fail_cnt + 11'd1;
               if (idx != last)
                  idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ROUND_LOG_EN
   logic [15:0] log_mem [MAXR];

   always_ff @(posedge clk) begin
      if (state == RECORD)
         log_mem[idx] <= cap;
      rd_data <= log_mem[rd_addr];
   end
`endif

endmodule

// File: tb/tb_nba_round_ctrl.sv
// Self-checking bench for nba_round_ctrl with a behavioural grader model.
// Log port checks are included when ROUND_LOG_EN is defined.
module tb_nba_round_ctrl;

   localparam int TIMEOUT = 200;
   localparam int AW      = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [10:0]   num_round;
   logic [AW-1:0] ans_addr;
   logic [15:0]   ans_data;
   logic [15:0]   answer;
   logic          round_rst_n;
   logic [15:0]   cnt;
   logic          correct;
   logic          busy;
   logic          done;
   logic [23:0]   total_cnt;
   logic [10:0]   fail_cnt;
   logic [15:0]   max_cnt;
`ifdef ROUND_LOG_EN
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;
`endif

   nba_round_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .num_round(num_round), .ans_addr(ans_addr),
      .ans_data(ans_data), .answer(answer),
      .round_rst_n(round_rst_n), .cnt(cnt),
      .correct(correct), .busy(busy), .done(done),
      .total_cnt(total_cnt), .fail_cnt(fail_cnt),
      .max_cnt(max_cnt)
`ifdef ROUND_LOG_EN
      , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
   );

   always #5 clk = ~clk;

   logic [15:0] ansmem [1024];
   logic [15:0] targ   [1024];
   int          caps   [1024];
   int          cnt_init = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   // Grader model: count restarts on the per-round reset, saturates at max.
   logic [15:0] gcnt = 16'd0;
   always @(posedge clk) begin
      if (!round_rst_n)
         gcnt <= 16'(cnt_init);
      else if (gcnt != 16'hFFFF)
         gcnt <= gcnt + 16'd1;
   end
   assign cnt      = gcnt;
   assign correct  = (gcnt == targ[ans_addr]);
   assign ans_data = ansmem[ans_addr];

   // Monitor of ARM pulses: count, width, address order, loaded answer.
   logic mon_clr = 1'b0;
   logic mon_en  = 1'b0;
   int   arm_cnt = 0;
   int   low_run = 0;
   int   seq_bad = 0;
   int   ans_bad = 0;
   int   pw_bad  = 0;
   always @(negedge clk) begin
      if (mon_clr) begin
         arm_cnt <= 0;
         low_run <= 0;
         seq_bad <= 0;
         ans_bad <= 0;
         pw_bad  <= 0;
      end else if (mon_en) begin
         if (!round_rst_n) begin
            low_run <= low_run + 1;
            if (low_run == 0) begin
               arm_cnt <= arm_cnt + 1;
               if (ans_addr !== AW'(arm_cnt))
                  seq_bad <= seq_bad + 1;
               if (answer !== ansmem[ans_addr])
                  ans_bad <= ans_bad + 1;
            end else begin
               pw_bad <= pw_bad + 1;
            end
         end else begin
            low_run <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One round from the spec rules: solve wins ties, else stop at TIMEOUT.
   function automatic void model(input int init, input int t,
                                 output int cap, output bit f);
      int  c;
      bit  fin;
      c   = init;
      fin = 0;
      cap = 0;
      f   = 0;
      while (!fin) begin
         if (c == t) begin
            cap = c; f = 0; fin = 1;
         end else if (c >= TIMEOUT) begin
            cap = c; f = 1; fin = 1;
         end else begin
            c++;
         end
      end
   endfunction

   task automatic run_batch(input int num, input int init,
                            input bit bstart, input string tag);
      int     n, cap, fl, mx, ecyc, cyc;
      bit     f;
      longint tot;
      n    = (num > 1024) ? 1024 : num;
      tot  = 0;
      mx   = 0;
      fl   = 0;
      ecyc = 0;
      for (int i = 0; i < n; i++) begin
         model(init, int'(targ[i]), cap, f);
         caps[i] = cap;
         tot    += cap;
         if (cap > mx) mx = cap;
         fl   += int'(f);
         ecyc += 3 + cap - init + 1;
      end
      if (tot > 64'hFFFFFF) tot = 64'hFFFFFF;
      cnt_init = init;
      @(negedge clk);
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr   = 1'b0;
      mon_en    = 1'b1;
      num_round = 11'(num);
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (done || cyc >= 40000) break;
         if (bstart && cyc == 5) begin
            start     = 1'b1;
            num_round = 11'd0;
         end
         @(posedge clk);
         #1;
         start     = 1'b0;
         num_round = 11'(num);
         cyc++;
      end
      mon_en = 1'b0;
      chk({tag, "_done"},   32'(done), 32'd1);
      chk({tag, "_busy"},   32'(busy), 32'd0);
      chk({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
      chk({tag, "_total"},  32'(total_cnt), 32'(tot));
      chk({tag, "_fail"},   32'(fail_cnt), 32'(fl));
      chk({tag, "_max"},    32'(max_cnt), 32'(mx));
      chk({tag, "_arms"},   32'(arm_cnt), 32'(n));
      chk({tag, "_addrseq"}, 32'(seq_bad), 32'd0);
      chk({tag, "_answer"}, 32'(ans_bad), 32'd0);
      chk({tag, "_pulsew"}, 32'(pw_bad), 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, "_hold_total"}, 32'(total_cnt), 32'(tot));
      chk({tag, "_hold_done"},  32'(done), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},  {29'd0, busy, done, round_rst_n}, 32'd0);
      chk({tag, "_answer"}, 32'(answer), 32'd0);
      chk({tag, "_addr"},   32'(ans_addr), 32'd0);
      chk({tag, "_stats"},  32'(total_cnt) | 32'(fail_cnt) | 32'(max_cnt),
          32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      num_round = 11'd0;
`ifdef ROUND_LOG_EN
      rd_addr   = '0;
`endif
      for (int i = 0; i < 1024; i++) begin
         ansmem[i] = 16'($urandom);
         targ[i]   = 16'd0;
      end
      #1 chk_reset_vals("por");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 chk("por_rrn_rel", 32'(round_rst_n), 32'd1);
      chk("por_idle", {30'd0, busy, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("por_noresume", 32'(busy), 32'd0);

      ansmem[0] = 16'h1234;
      targ[0]   = 16'd7;
      run_batch(1, 0, 0, "single");
      chk("single_ans", 32'(answer), 32'h1234);

      targ[0] = 16'd1000;
      run_batch(1, 0, 0, "timeout");

      targ[0] = 16'd200;
      run_batch(1, 0, 0, "simul");

      targ[0] = 16'd5;
      targ[1] = 16'd9;
      targ[2] = 16'd4;
      run_batch(3, 0, 0, "batch3");
`ifdef ROUND_LOG_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rd_addr = AW'(i);
         @(negedge clk);
         chk("log_rd", 32'(rd_data), 32'(caps[i]));
      end
`endif

      run_batch(0, 0, 0, "zero");

      targ[0] = 16'($urandom_range(0, 150));
      targ[1] = 16'($urandom_range(0, 150));
      run_batch(2, 0, 1, "busystart");

      for (int k = 0; k < 4; k++) begin
         int nr;
         nr = int'($urandom_range(1, 12));
         for (int i = 0; i < nr; i++)
            targ[i] = 16'($urandom_range(0, 260));
         run_batch(nr, int'($urandom_range(0, 3)), 0, "rand");
      end

      for (int i = 0; i < 1024; i++)
         targ[i] = 16'd0;
      run_batch(2000, 65000, 0, "clamp_sat");

      for (int i = 0; i < 3; i++) begin
         targ[i]   = 16'd150;
         ansmem[i] = 16'hA5A0 | 16'(i + 1);
      end
      cnt_init = 0;
      @(negedge clk);
      num_round = 11'd3;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      begin
         int w;
         w = 0;
         while (!(ans_addr == AW'(1) && round_rst_n && busy &&
                  answer == ansmem[1]) && w < 2000) begin
            @(negedge clk);
            w++;
         end
         chk("rst_reach_r2", 32'(w < 2000), 32'd1);
      end
      repeat (20) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_reset_vals("midrun");
      @(posedge clk);
      #1 chk_reset_vals("midrun_held");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 chk("midrun_rrn_rel", 32'(round_rst_n), 32'd1);
      repeat (10) @(negedge clk);
      chk("midrun_idle", {30'd0, busy, done}, 32'd0);
      chk("midrun_stats", 32'(total_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nba_round_ctrl.md
NBA_ROUND_CTRL -- requirements
Module: nba_round_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
- TIMEOUT, 200, question count at which a round is abandoned.
- ADDR_W, 10, answer-store address width (max 1024 rounds).

REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a batch.
- num_round  in  11  rounds in the batch; values above 1024 are clamped to 1024.
- ans_addr  out  ADDR_W  address into the answer store.
- ans_data  in  16  answer word; combinational read, valid in the same cycle as ans_addr.
- answer  out  16  registered answer driven to the grader.
- round_rst_n  out  1  active-low per-round reset to the solver and grader.
- cnt  in  16  grader question count.
- correct  in  1  grader solved flag.
- busy  out  1  batch in progress.
- done  out  1  batch finished; level signal.
- total_cnt  out  24  sum of the recorded cnt over all rounds.
- fail_cnt  out  11  rounds that hit TIMEOUT without correct.
- max_cnt  out  16  largest recorded cnt.
- rd_addr  in  ADDR_W  per-round log read address (ROUND_LOG_EN only).
- rd_data  out  16  per-round log read data (ROUND_LOG_EN only).

Function
REQ-003 FSM states SHALL be IDLE, LOAD, ARM, RUN, RECORD and DONE.

REQ-004 start in IDLE or DONE SHALL clear all statistics, set idx=0 and go to LOAD on the next cycle. start in any other state is ignored.

REQ-005 start with num_round=0 SHALL go directly to DONE with all statistics zero.

REQ-006 LOAD SHALL drive ans_addr=idx and register ans_data into answer at the end of the cycle, then go to ARM.

REQ-007 ARM SHALL drive round_rst_n=0 for exactly one cycle, then go to RUN.

REQ-008 round_rst_n SHALL be 1 in every state except ARM. The reset value of round_rst_n is covered in REQ-016.

REQ-009 RUN SHALL sample correct and cnt every cycle.
- correct=1 captures cnt and goes to RECORD.
- cnt>=TIMEOUT captures cnt and goes to RECORD.
- If both occur in the same cycle, the round counts as solved.

REQ-010 RECORD (one cycle) SHALL:
- add the captured cnt to total_cnt;
- set max_cnt = max(max_cnt, cnt);
- increment fail_cnt if the round timed out.

REQ-011 After RECORD, the FSM SHALL go to DONE if idx = clamped num_round - 1; otherwise it increments idx and goes to LOAD.

REQ-012 Each round SHALL cost exactly 3 overhead cycles (LOAD, ARM, RECORD) plus its RUN cycles.

REQ-013 total_cnt SHALL saturate at 24'hFFFFFF and SHALL NOT wrap. fail_cnt cannot overflow because it is bounded by 1024.

REQ-014 busy SHALL be 1 in LOAD, ARM, RUN and RECORD. done SHALL be 1 only in DONE.

REQ-015 Statistic outputs SHALL hold their values in DONE until the next accepted start.

Reset
REQ-016 Asserting reset (low) at any time, including mid-round, SHALL asynchronously force:
- state=IDLE, idx=0;
- answer=0, ans_addr=0;
- round_rst_n=0;
- busy=0, done=0;
- total_cnt=0, fail_cnt=0, max_cnt=0.

REQ-017 round_rst_n SHALL go to 1 on the first clock edge after reset deasserts.

REQ-018 No batch SHALL resume after reset. A new start is required.

Configuration
REQ-019 With ROUND_LOG_EN defined, RECORD SHALL write the captured cnt to a 2^ADDR_W x 16 log at address idx. rd_data SHALL return log[rd_addr] one cycle after rd_addr is presented. Log contents are not reset.

REQ-020 Without ROUND_LOG_EN:
- the log memory, rd_addr and rd_data SHALL be absent;
- all other behaviour is unchanged.

Verification
REQ-021 Single round: num_round=1, ans_data=16'h1234, correct asserted when cnt=7 -> answer=1234, one-cycle round_rst_n low pulse, total_cnt=7, max_cnt=7, fail_cnt=0, done=1.

REQ-022 Timeout: correct never asserted, cnt ramps to 200 -> captured cnt=200, fail_cnt=1, total_cnt=200.

REQ-023 Simultaneous: correct=1 in the same cycle as cnt=200 -> fail_cnt=0, total_cnt=200.

REQ-024 Batch: num_round=3 with solve counts 5, 9 and 4 -> total_cnt=18, max_cnt=9, ans_addr sequence 0,1,2, three ARM pulses. With ROUND_LOG_EN, log[0..2] reads 5, 9, 4.

REQ-025 Edge starts:
- num_round=0 -> done the cycle after start, all statistics 0.
- num_round=2000 -> 1024 rounds run.
- start while busy -> ignored.

REQ-026 Reset mid-RUN in round 2 -> all outputs return to reset values immediately and round_rst_n=0. After release, the block idles until start.
